// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with one outstanding imem request,
// a small instruction FIFO feeding dispatch, branch redirect with epoch-based
// discard of in-flight responses, and optional HLT detection.
//
// Optional feature macro: FETCH_HALT_DETECT_EN (HLT detection / stop fetching).
//
// Ports:
//   in_clk, in_rst_n          clock, async active-low reset
//   in_stall                  downstream stall (hold outputs, no pop)
//   in_redirect(_pc)          branch redirect pulse and target PC
//   out_imem_req/_addr        registered request strobe and address
//   in_imem_valid/_data       instruction-memory response
//   out_reg_insnbits/_pc      delivered instruction and its PC
//   out_reg_done              one-cycle delivery pulse
//   out_halted                HLT has been delivered
module fetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_stall,
    input  logic        in_redirect,
    input  logic [63:0] in_redirect_pc,
    output logic        out_imem_req,
    output logic [63:0] out_imem_addr,
    input  logic        in_imem_valid,
    input  logic [31:0] in_imem_data,
    output logic [31:0] out_reg_insnbits,
    output logic [63:0] out_reg_pc,
    output logic        out_reg_done,
    output logic        out_halted
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned INF_W = CNT_W + 1;

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALTED} state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
    } entry_t;

    state_e             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               outstanding_q, outstanding_d;
    logic               epoch_q, epoch_d;
    logic               req_epoch_q, req_epoch_d;
    logic               req_q, req_d;
    logic [63:0]        addr_q, addr_d;
    logic [31:0]        insn_q, insn_d;
    logic [63:0]        rpc_q, rpc_d;
    logic               done_q, done_d;
    logic               halted_q, halted_d;

    entry_t             mem [QUEUE_DEPTH];

    logic               push_c, pop_c, resp_c, resp_ok_c, credit_c;
    logic               hlt_resp_c, hlt_head_c;
    logic [INF_W-1:0]   inflight_c;

`ifdef FETCH_HALT_DETECT_EN
    function automatic logic is_hlt(input logic [31:0] w);
        return (w & 32'hFFE0_001F) == 32'hD440_0000;
    endfunction
    assign hlt_resp_c = is_hlt(in_imem_data);
    assign hlt_head_c = is_hlt(mem[head_q].insn);
`else
    assign hlt_resp_c = 1'b0;
    assign hlt_head_c = 1'b0;
`endif

    // Valid is only meaningful while a request is in flight; this also drops
    // responses to requests that were cut off by reset.
    assign resp_c     = in_imem_valid && outstanding_q;
    assign resp_ok_c  = resp_c && (req_epoch_q == epoch_q);
    assign inflight_c = {1'b0, count_q} + INF_W'(outstanding_q);
    assign credit_c   = inflight_c < INF_W'(QUEUE_DEPTH);

    // Next-state: redirect, response handling, request issue, FIFO pop.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        epoch_d       = epoch_q;
        req_epoch_d   = req_epoch_q;
        req_d         = 1'b0;
        addr_d        = addr_q;
        insn_d        = insn_q;
        rpc_d         = rpc_q;
        done_d        = 1'b0;
        halted_d      = halted_q;
        push_c        = 1'b0;
        pop_c         = 1'b0;

        if (in_redirect) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            pc_d     = in_redirect_pc;
            epoch_d  = ~epoch_q;
            state_d  = ST_RUN;
            halted_d = 1'b0;
            if (resp_c) begin
                outstanding_d = 1'b0;
            end else begin
                // Pin the in-flight tag to the old epoch so a second redirect
                // before the response cannot make it match again.
                req_epoch_d = epoch_q;
            end
        end else begin
            pop_c = !in_stall && (count_q != '0);
            if (resp_c) begin
                outstanding_d = 1'b0;
                push_c        = resp_ok_c;
                state_d       = (resp_ok_c && hlt_resp_c) ? ST_HALTED : ST_RUN;
            end else if (state_q == ST_RUN && !outstanding_q && credit_c) begin
                req_d         = 1'b1;
                addr_d        = pc_q;
                pc_d          = pc_q + 64'd4;
                outstanding_d = 1'b1;
                req_epoch_d   = epoch_q;
                state_d       = ST_WAIT;
            end
            if (push_c) tail_d = tail_q + PTR_W'(1);
            if (pop_c) begin
                head_d = head_q + PTR_W'(1);
                done_d = 1'b1;
                insn_d = mem[head_q].insn;
                rpc_d  = mem[head_q].pc;
                if (hlt_head_c) halted_d = 1'b1;
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // State and output registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            epoch_q       <= 1'b0;
            req_epoch_q   <= 1'b0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            insn_q        <= '0;
            rpc_q         <= '0;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            epoch_q       <= epoch_d;
            req_epoch_q   <= req_epoch_d;
            req_q         <= req_d;
            addr_q        <= addr_d;
            insn_q        <= insn_d;
            rpc_q         <= rpc_d;
            done_q        <= done_d;
            halted_q      <= halted_d;
        end
    end

    // FIFO storage; the entry PC is the address of the request being answered.
    always_ff @(posedge in_clk) begin
        if (push_c) mem[tail_q] <= '{pc: addr_q, insn: in_imem_data};
    end

    // Credit accounting must make a push into a full FIFO unreachable.
    always_ff @(posedge in_clk) begin
        if (in_rst_n && push_c) assert (count_q != CNT_W'(QUEUE_DEPTH));
    end

    assign out_imem_req     = req_q;
    assign out_imem_addr    = addr_q;
    assign out_reg_insnbits = insn_q;
    assign out_reg_pc       = rpc_q;
    assign out_reg_done     = done_q;
    assign out_halted       = halted_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_stall;
    logic        in_redirect;
    logic [63:0] in_redirect_pc;
    logic        out_imem_req;
    logic [63:0] out_imem_addr;
    logic        in_imem_valid;
    logic [31:0] in_imem_data;
    logic [31:0] out_reg_insnbits;
    logic [63:0] out_reg_pc;
    logic        out_reg_done;
    logic        out_halted;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(64'h0)) dut (
        .in_clk          (in_clk),
        .in_rst_n        (in_rst_n),
        .in_stall        (in_stall),
        .in_redirect     (in_redirect),
        .in_redirect_pc  (in_redirect_pc),
        .out_imem_req    (out_imem_req),
        .out_imem_addr   (out_imem_addr),
        .in_imem_valid   (in_imem_valid),
        .in_imem_data    (in_imem_data),
        .out_reg_insnbits(out_reg_insnbits),
        .out_reg_pc      (out_reg_pc),
        .out_reg_done    (out_reg_done),
        .out_halted      (out_halted)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every delivered instruction must match the oldest expected one.
    always @(negedge in_clk) begin
        if (in_rst_n === 1'b1 && out_reg_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'(out_reg_done), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deliver_insn", 64'(out_reg_insnbits), 64'(e.insn));
                chk("deliver_pc", out_reg_pc, e.pc);
            end
        end
    end

    task automatic do_reset(input logic stall_val);
        chk("leftover_expected", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        in_rst_n       = 1'b0;
        in_stall       = stall_val;
        in_redirect    = 1'b0;
        in_redirect_pc = '0;
        in_imem_valid  = 1'b0;
        in_imem_data   = '0;
        repeat (2) @(negedge in_clk);
        in_rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [63:0] exp_addr);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge in_clk);
            if (out_imem_req === 1'b1) seen = 1'b1;
        end
        if (seen) chk(tag, out_imem_addr, exp_addr);
        else      chk({tag, "_timeout"}, 64'(out_imem_req), 64'd1);
    endtask

    task automatic respond(input int lat, input logic [31:0] data, input logic [63:0] pc,
                           input bit push);
        repeat (lat) @(negedge in_clk);
        in_imem_valid = 1'b1;
        in_imem_data  = data;
        if (push) exp_q.push_back('{pc: pc, insn: data});
        @(negedge in_clk);
        in_imem_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge in_clk);
        @(negedge in_clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        in_rst_n       = 1'b0;
        in_stall       = 1'b0;
        in_redirect    = 1'b0;
        in_redirect_pc = '0;
        in_imem_valid  = 1'b0;
        in_imem_data   = '0;

        // Reset values, then two back-to-back fetches.
        @(negedge in_clk);
        chk("rst_req", 64'(out_imem_req), 64'd0);
        chk("rst_addr", out_imem_addr, 64'd0);
        chk("rst_insn", 64'(out_reg_insnbits), 64'd0);
        chk("rst_pc", out_reg_pc, 64'd0);
        chk("rst_done", 64'(out_reg_done), 64'd0);
        chk("rst_halted", 64'(out_halted), 64'd0);
        do_reset(1'b0);
        wait_req("t1_req0", 64'h0);
        respond(1, 32'h9100_0421, 64'h0, 1'b1);
        wait_req("t1_req4", 64'h4);
        respond(1, 32'hD280_0020, 64'h4, 1'b1);
        wait_drain("t1_drain");

        // Stall fills the FIFO; no fifth request; release drains back-to-back.
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_req("t2_req", 64'(i * 4));
            respond(1, 32'h1100_0000 + 32'(i), 64'(i * 4), 1'b1);
        end
        n = 0;
        repeat (10) begin
            @(negedge in_clk);
            if (out_imem_req === 1'b1) n++;
        end
        chk("t2_no_5th_req", 64'(n), 64'd0);
        chk("t2_held_done", 64'(out_reg_done), 64'd0);
        in_stall = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge in_clk);
            if (out_reg_done === 1'b1) n++;
        end
        chk("t2_consecutive", 64'(n), 64'd4);
        wait_drain("t2_drain");

        // Redirect while the request to 0x8 is outstanding (3-cycle latency).
        do_reset(1'b0);
        wait_req("t3_req0", 64'h0);
        respond(1, 32'h2200_0000, 64'h0, 1'b1);
        wait_req("t3_req4", 64'h4);
        respond(1, 32'h2200_0004, 64'h4, 1'b1);
        wait_req("t3_req8", 64'h8);
        @(negedge in_clk);
        in_redirect    = 1'b1;
        in_redirect_pc = 64'h100;
        @(negedge in_clk);
        in_redirect = 1'b0;
        chk("t3_no_req_a", 64'(out_imem_req), 64'd0);
        @(negedge in_clk);
        chk("t3_no_req_b", 64'(out_imem_req), 64'd0);
        in_imem_valid = 1'b1;
        in_imem_data  = 32'hDEAD_0008;
        @(negedge in_clk);
        in_imem_valid = 1'b0;
        chk("t3_no_req_c", 64'(out_imem_req), 64'd0);
        wait_req("t3_req100", 64'h100);
        respond(1, 32'h2200_0100, 64'h100, 1'b1);
        wait_drain("t3_drain");

        // Redirect coincident with a response and a non-stalled pop.
        do_reset(1'b1);
        wait_req("t4_req0", 64'h0);
        respond(1, 32'h3300_0000, 64'h0, 1'b1);
        wait_req("t4_req4", 64'h4);
        respond(1, 32'h3300_0004, 64'h4, 1'b1);
        wait_req("t4_req8", 64'h8);
        @(negedge in_clk);
        in_imem_valid  = 1'b1;
        in_imem_data   = 32'h3300_0008;
        in_stall       = 1'b0;
        in_redirect    = 1'b1;
        in_redirect_pc = 64'h200;
        exp_q.delete();
        @(negedge in_clk);
        in_imem_valid = 1'b0;
        in_redirect   = 1'b0;
        chk("t4_pop_cancelled", 64'(out_reg_done), 64'd0);
        @(negedge in_clk);
        chk("t4_fifo_empty", 64'(out_reg_done), 64'd0);
        chk("t4_req200", 64'(out_imem_req), 64'd1);
        chk("t4_addr200", out_imem_addr, 64'h200);
        respond(1, 32'h3300_0200, 64'h200, 1'b1);
        wait_drain("t4_drain");

        // HLT at PC 0x8.
        do_reset(1'b0);
        wait_req("t5_req0", 64'h0);
        respond(1, 32'h4400_0000, 64'h0, 1'b1);
        wait_req("t5_req4", 64'h4);
        respond(1, 32'h4400_0004, 64'h4, 1'b1);
        wait_req("t5_req8", 64'h8);
        respond(1, 32'hD440_0000, 64'h8, 1'b1);
`ifdef FETCH_HALT_DETECT_EN
        wait_drain("t5_drain");
        chk("t5_halted", 64'(out_halted), 64'd1);
        n = 0;
        repeat (20) begin
            @(negedge in_clk);
            if (out_imem_req === 1'b1) n++;
        end
        chk("t5_no_req_after_hlt", 64'(n), 64'd0);
        chk("t5_still_halted", 64'(out_halted), 64'd1);
`else
        wait_req("t5_reqC", 64'hC);
        wait_drain("t5_drain");
        chk("t5_not_halted", 64'(out_halted), 64'd0);
`endif

        // Reset in the middle of WAIT, then a stale response right after release.
        do_reset(1'b0);
        wait_req("t6_req0", 64'h0);
        respond(1, 32'h5500_0000, 64'h0, 1'b1);
        wait_req("t6_req4", 64'h4);
        wait_drain("t6_pre_drain");
        in_rst_n = 1'b0;
        @(negedge in_clk);
        chk("t6_rst_req", 64'(out_imem_req), 64'd0);
        chk("t6_rst_addr", out_imem_addr, 64'd0);
        chk("t6_rst_insn", 64'(out_reg_insnbits), 64'd0);
        chk("t6_rst_pc", out_reg_pc, 64'd0);
        chk("t6_rst_done", 64'(out_reg_done), 64'd0);
        chk("t6_rst_halted", 64'(out_halted), 64'd0);
        @(negedge in_clk);
        in_rst_n      = 1'b1;
        in_imem_valid = 1'b1;
        in_imem_data  = 32'hBAD0_0BAD;
        @(negedge in_clk);
        in_imem_valid = 1'b0;
        chk("t6_restart_req", 64'(out_imem_req), 64'd1);
        chk("t6_restart_addr", out_imem_addr, 64'h0);
        respond(1, 32'h5500_1000, 64'h0, 1'b1);
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
